// File: rtl/sha256_id_issue.sv
// Grants one of two message requesters to the SHA-256 message builder,
// issues a 6-bit transaction ID per granted packet, and tracks how many IDs
// are outstanding (issued but not yet retired by done_valid).
module sha256_id_issue #(
   parameter int DATA_W       = 512,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              en,
   input  logic              sync_rst,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_last,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_last,
   input  logic              req1_valid,
   output logic              req1_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_last,
   output logic              data_out_valid,
   input  logic              data_out_ready,
   output logic [5:0]        id_out,
   output logic              id_out_last,
   output logic              id_out_valid,
   input  logic              id_out_ready,
   input  logic              done_valid,
   output logic [5:0]        status_id,
   output logic [5:0]        status_inflight,
   output logic              status_src,
   output logic              err_underflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2
   } state_t;

   localparam logic [5:0] MAX_CNT = 6'(MAX_INFLIGHT);

   state_t     state;
   state_t     state_nxt;
   logic       grant;
   logic       grant_nxt;
   logic       rr_ptr;
   logic [5:0] next_id;
   logic [5:0] inflight;
   logic       pick;
   logic       sel_valid;
   logic       sel_last;
   logic       id_fire;
   logic       last_fire;

   // Preferred requester wins when valid, otherwise the other one.
   assign pick      = rr_ptr ? req1_valid : ~req0_valid;
   assign sel_valid = grant ? req1_valid : req0_valid;
   assign sel_last  = grant ? req1_last : req0_last;
   assign id_fire   = (state == ISSUE) && id_out_ready;
   assign last_fire = (state == XFER) && sel_valid && data_out_ready && sel_last;

   assign id_out          = next_id;
   assign status_inflight = inflight;

   // Next-state decode and stream steering for the grant FSM.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      id_out_valid   = 1'b0;
      id_out_last    = 1'b0;
      data_out       = grant ? req1_data : req0_data;
      data_out_valid = 1'b0;
      data_out_last  = 1'b0;
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      case (state)
         IDLE: begin
            if (en && (inflight < MAX_CNT) && (req0_valid || req1_valid)) begin
               grant_nxt = pick;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            id_out_valid = 1'b1;
            id_out_last  = 1'b1;
            if (id_out_ready) begin
               state_nxt = XFER;
            end
         end
         XFER: begin
            data_out_valid = sel_valid;
            data_out_last  = sel_last;
            req0_ready     = ~grant & data_out_ready;
            req1_ready     = grant & data_out_ready;
            if (last_fire) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM, ID counter, credit counter and status registers; sync_rst beats all.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= IDLE;
         grant         <= 1'b0;
         rr_ptr        <= 1'b0;
         next_id       <= 6'd0;
         inflight      <= 6'd0;
         status_id     <= 6'd0;
         status_src    <= 1'b0;
         err_underflow <= 1'b0;
      end else if (sync_rst) begin
         state         <= IDLE;
         grant         <= 1'b0;
         rr_ptr        <= 1'b0;
         next_id       <= 6'd0;
         inflight      <= 6'd0;
         status_id     <= 6'd0;
         status_src    <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         if (id_fire) begin
            status_id  <= next_id;
            status_src <= grant;
            next_id    <= next_id + 6'd1;
         end
         if (last_fire) begin
            rr_ptr <= ~grant;
         end
         // A retire in the same cycle as an issue cancels out.
         if (id_fire && !done_valid) begin
            inflight <= inflight + 6'd1;
         end else if (!id_fire && done_valid) begin
            if (inflight != 6'd0) begin
               inflight <= inflight - 6'd1;
            end else begin
               err_underflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sha256_id_issue.sv
// Bench for sha256_id_issue: directed scenarios plus randomized traffic
// compared against a packet-level arbitration/ID model.
module tb_sha256_id_issue;

   localparam int DW   = 512;
   localparam int MAXI = 8;

   logic          clk = 1'b0;
   logic          nrst, en, sync_rst;
   logic [DW-1:0] req0_data, req1_data, data_out;
   logic          req0_last, req0_valid, req0_ready;
   logic          req1_last, req1_valid, req1_ready;
   logic          data_out_last, data_out_valid, data_out_ready;
   logic [5:0]    id_out, status_id, status_inflight;
   logic          id_out_last, id_out_valid, id_out_ready;
   logic          done_valid, status_src, err_underflow;

   always #5 clk = ~clk;

   sha256_id_issue #(.DATA_W(DW), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
      .req0_data(req0_data), .req0_last(req0_last), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_data(req1_data), .req1_last(req1_last), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .data_out(data_out), .data_out_last(data_out_last), .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .id_out(id_out), .id_out_last(id_out_last), .id_out_valid(id_out_valid), .id_out_ready(id_out_ready),
      .done_valid(done_valid), .status_id(status_id), .status_inflight(status_inflight),
      .status_src(status_src), .err_underflow(err_underflow)
   );

   typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
   typedef struct packed {logic [DW-1:0] data; logic last; logic src; logic ssrc;} obs_t;

   beat_t      s0_q[$], s1_q[$], m0_q[$], m1_q[$];
   obs_t       obs_q[$], exp_q[$];
   logic [5:0] oid_q[$];
   int         nvec = 0, nfail = 0, mi = 0;
   bit         auto_on = 0, f0 = 0, f1 = 0;
   int         p_idr = 100, p_dr = 100, p_en = 100, p_done = 0;

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Packet-level model: winner alternates while both have packets queued.
   function automatic void build_model();
      bit    rr = 1'b0;
      bit    w;
      beat_t b;
      obs_t  e;
      exp_q.delete();
      while (m0_q.size() > 0 || m1_q.size() > 0) begin
         if (m0_q.size() == 0) w = 1'b1;
         else if (m1_q.size() == 0) w = 1'b0;
         else w = rr;
         do begin
            if (w) b = m1_q.pop_front();
            else b = m0_q.pop_front();
            e.data = b.data; e.last = b.last; e.src = w; e.ssrc = w;
            exp_q.push_back(e);
         end while (!b.last);
         rr = ~w;
      end
   endfunction

   task automatic load(input bit who, input int npkt, input int maxlen);
      beat_t bt;
      int    len;
      for (int p = 0; p < npkt; p++) begin
         len = $urandom_range(maxlen, 1);
         for (int b = 0; b < len; b++) begin
            bt.data = rnd_data();
            bt.last = (b == len - 1);
            if (who) begin s1_q.push_back(bt); m1_q.push_back(bt); end
            else begin s0_q.push_back(bt); m0_q.push_back(bt); end
         end
      end
   endtask

   // One clock: sample handshakes on settled inputs, take the edge, then drive.
   task automatic step();
      obs_t o;
      bit   idf;
      #1;
      f0 = 0; f1 = 0;
      if (nrst && !sync_rst) begin
         f0  = req0_valid && req0_ready;
         f1  = req1_valid && req1_ready;
         idf = id_out_valid && id_out_ready;
         if (idf) oid_q.push_back(id_out);
         if (idf && !done_valid) mi++;
         else if (!idf && done_valid && mi > 0) mi--;
         if (data_out_valid && data_out_ready) begin
            o.data = data_out; o.last = data_out_last; o.src = req1_ready; o.ssrc = status_src;
            obs_q.push_back(o);
         end
      end
      @(posedge clk);
      #1;
      if (auto_on) begin
         if (f0 && s0_q.size() > 0) void'(s0_q.pop_front());
         if (f1 && s1_q.size() > 0) void'(s1_q.pop_front());
         req0_valid = (s0_q.size() > 0);
         if (s0_q.size() > 0) begin req0_data = s0_q[0].data; req0_last = s0_q[0].last; end
         req1_valid = (s1_q.size() > 0);
         if (s1_q.size() > 0) begin req1_data = s1_q[0].data; req1_last = s1_q[0].last; end
         id_out_ready   = ($urandom_range(99) < p_idr);
         data_out_ready = ($urandom_range(99) < p_dr);
         en             = ($urandom_range(99) < p_en);
         done_valid     = (mi > 0) && ($urandom_range(99) < p_done);
      end
   endtask

   task automatic do_reset();
      auto_on = 0; f0 = 0; f1 = 0;
      s0_q.delete(); s1_q.delete(); m0_q.delete(); m1_q.delete();
      req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
      done_valid = 0; en = 1; id_out_ready = 1; data_out_ready = 1;
      p_idr = 100; p_dr = 100; p_en = 100; p_done = 0;
      sync_rst = 1;
      step();
      sync_rst = 0;
      obs_q.delete(); exp_q.delete(); oid_q.delete(); mi = 0;
   endtask

   task automatic test_reset();
      nrst = 0; sync_rst = 0; en = 1; done_valid = 0;
      req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
      req0_data = '0; req1_data = '0; id_out_ready = 1; data_out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      nvec++; if ({id_out_valid, data_out_valid, req0_ready, req1_ready} !== 4'b0) begin
         nfail++; $display("FAIL reset_valids got %b expected 0000", {id_out_valid, data_out_valid, req0_ready, req1_ready}); end
      nvec++; if ({status_id, status_inflight} !== 12'd0) begin
         nfail++; $display("FAIL reset_status got id=%0d inflight=%0d expected 0/0", status_id, status_inflight); end
      nvec++; if ({status_src, err_underflow} !== 2'b00) begin
         nfail++; $display("FAIL reset_flags got src=%b err=%b expected 0/0", status_src, err_underflow); end
      nrst = 1;
      req0_valid = 1; req0_last = 1; req0_data = rnd_data();
      step();
      #1;
      nvec++; if (id_out_valid !== 1'b1) begin
         nfail++; $display("FAIL pre_async_issue got id_out_valid=%b expected 1", id_out_valid); end
      nrst = 0;
      #1;
      nvec++; if (id_out_valid !== 1'b0) begin
         nfail++; $display("FAIL async_reset got id_out_valid=%b expected 0", id_out_valid); end
      req0_valid = 0;
      @(posedge clk);
      #1 nrst = 1;
   endtask

   task automatic test_single();
      logic [DW-1:0] d[3];
      do_reset();
      for (int b = 0; b < 3; b++) d[b] = rnd_data();
      req0_valid = 1; req0_data = d[0]; req0_last = 0;
      step();
      #1;
      nvec++; if ({id_out_valid, id_out_last, id_out} !== {2'b11, 6'd0}) begin
         nfail++; $display("FAIL single_id got v=%b l=%b id=%0d expected 1/1/0", id_out_valid, id_out_last, id_out); end
      nvec++; if ({data_out_valid, req0_ready} !== 2'b00) begin
         nfail++; $display("FAIL single_issue_quiet got dv=%b r0=%b expected 0/0", data_out_valid, req0_ready); end
      step();
      for (int b = 0; b < 3; b++) begin
         req0_data = d[b]; req0_last = (b == 2);
         #1;
         nvec++; if ({data_out_valid, data_out_last, req0_ready, data_out} !== {1'b1, (b == 2), 1'b1, d[b]}) begin
            nfail++; $display("FAIL single_beat%0d got v=%b l=%b r=%b d=%h expected 1/%0d/1/%h",
                              b, data_out_valid, data_out_last, req0_ready, data_out[31:0], (b == 2), d[b][31:0]); end
         step();
      end
      req0_valid = 0;
      #1;
      nvec++; if ({status_id, status_inflight, status_src} !== {6'd0, 6'd1, 1'b0}) begin
         nfail++; $display("FAIL single_status got id=%0d inflight=%0d src=%b expected 0/1/0", status_id, status_inflight, status_src); end
   endtask

   task automatic test_contention();
      int n;
      do_reset();
      load(0, 4, 1); load(1, 4, 1);
      build_model();
      auto_on = 1;
      for (n = 0; n < 300 && obs_q.size() < exp_q.size(); n++) step();
      nvec++; if (obs_q.size() != exp_q.size()) begin
         nfail++; $display("FAIL contention_count got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         nvec++; if (obs_q[k] !== exp_q[k]) begin
            nfail++; $display("FAIL contention_beat%0d got src=%b ssrc=%b d=%h expected src=%b d=%h",
                              k, obs_q[k].src, obs_q[k].ssrc, obs_q[k].data[31:0], exp_q[k].src, exp_q[k].data[31:0]); end
      end
      for (int k = 0; k < oid_q.size(); k++) begin
         nvec++; if (oid_q[k] !== 6'(k)) begin
            nfail++; $display("FAIL contention_id%0d got %0d expected %0d", k, oid_q[k], k); end
      end
   endtask

   task automatic test_credit();
      do_reset();
      load(0, 10, 1);
      auto_on = 1;
      repeat (100) step();
      nvec++; if (oid_q.size() != MAXI) begin
         nfail++; $display("FAIL credit_stall got %0d ids expected %0d", oid_q.size(), MAXI); end
      #1;
      nvec++; if ({status_inflight, id_out_valid} !== {6'(MAXI), 1'b0}) begin
         nfail++; $display("FAIL credit_hold got inflight=%0d idv=%b expected %0d/0", status_inflight, id_out_valid, MAXI); end
      done_valid = 1;
      step();
      repeat (20) step();
      nvec++; if (oid_q.size() != MAXI + 1 || oid_q[oid_q.size() - 1] !== 6'(MAXI)) begin
         nfail++; $display("FAIL credit_release got %0d ids expected %0d ending in id %0d", oid_q.size(), MAXI + 1, MAXI); end
      nvec++; if (status_inflight !== 6'(MAXI)) begin
         nfail++; $display("FAIL credit_inflight got %0d expected %0d", status_inflight, MAXI); end
   endtask

   task automatic test_wrap();
      int n;
      do_reset();
      load(0, 65, 1);
      auto_on = 1; p_done = 100;
      for (n = 0; n < 2000 && oid_q.size() < 65; n++) step();
      nvec++; if (oid_q.size() != 65) begin
         nfail++; $display("FAIL wrap_count got %0d ids expected 65", oid_q.size()); end
      for (int k = 0; k < oid_q.size(); k++) begin
         nvec++; if (oid_q[k] !== 6'(k % 64)) begin
            nfail++; $display("FAIL wrap_id%0d got %0d expected %0d", k, oid_q[k], k % 64); end
      end
      nvec++; if (err_underflow !== 1'b0) begin
         nfail++; $display("FAIL wrap_err got %b expected 0", err_underflow); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d;
      do_reset();
      d = rnd_data();
      req1_valid = 1; req1_data = d; req1_last = 1; id_out_ready = 0;
      step();
      for (int c = 0; c < 5; c++) begin
         #1;
         nvec++; if ({id_out_valid, id_out, data_out_valid, req1_ready} !== {1'b1, 6'd0, 2'b00}) begin
            nfail++; $display("FAIL bp_hold%0d got idv=%b id=%0d dv=%b r1=%b expected 1/0/0/0",
                              c, id_out_valid, id_out, data_out_valid, req1_ready); end
         step();
      end
      id_out_ready = 1;
      step();
      #1;
      nvec++; if ({data_out_valid, req1_ready, data_out} !== {2'b11, d}) begin
         nfail++; $display("FAIL bp_beat got dv=%b r1=%b d=%h expected 1/1/%h", data_out_valid, req1_ready, data_out[31:0], d[31:0]); end
      step();
      req1_valid = 0;
      #1;
      nvec++; if ({status_src, status_id} !== {1'b1, 6'd0}) begin
         nfail++; $display("FAIL bp_status got src=%b id=%0d expected 1/0", status_src, status_id); end
   endtask

   task automatic test_enable();
      do_reset();
      en = 0; req0_valid = 1; req0_last = 1; req0_data = rnd_data();
      for (int c = 0; c < 3; c++) begin
         step();
         #1;
         nvec++; if (id_out_valid !== 1'b0) begin
            nfail++; $display("FAIL en_block%0d got idv=%b expected 0", c, id_out_valid); end
      end
      en = 1;
      step();
      #1;
      nvec++; if (id_out_valid !== 1'b1) begin
         nfail++; $display("FAIL en_grant got idv=%b expected 1", id_out_valid); end
      en = 0;
      step();
      #1;
      nvec++; if (data_out_valid !== 1'b1) begin
         nfail++; $display("FAIL en_complete got dv=%b expected 1", data_out_valid); end
      step();
      step();
      #1;
      nvec++; if (id_out_valid !== 1'b0) begin
         nfail++; $display("FAIL en_no_regrant got idv=%b expected 0", id_out_valid); end
      req0_valid = 0; en = 1;
   endtask

   task automatic test_corner();
      do_reset();
      req0_valid = 1; req0_last = 1; req0_data = rnd_data();
      step(); step(); step();
      step();
      done_valid = 1;
      step();
      done_valid = 0;
      #1;
      nvec++; if ({status_inflight, status_id} !== {6'd1, 6'd1}) begin
         nfail++; $display("FAIL corner_coincident got inflight=%0d id=%0d expected 1/1", status_inflight, status_id); end
      step();
      req0_valid = 0;
      done_valid = 1;
      step();
      done_valid = 0;
      #1;
      nvec++; if ({status_inflight, err_underflow} !== {6'd0, 1'b0}) begin
         nfail++; $display("FAIL corner_retire got inflight=%0d err=%b expected 0/0", status_inflight, err_underflow); end
      done_valid = 1;
      step();
      done_valid = 0;
      #1;
      nvec++; if ({status_inflight, err_underflow} !== {6'd0, 1'b1}) begin
         nfail++; $display("FAIL corner_underflow got inflight=%0d err=%b expected 0/1", status_inflight, err_underflow); end
      step();
      #1;
      nvec++; if (err_underflow !== 1'b1) begin
         nfail++; $display("FAIL corner_sticky got err=%b expected 1", err_underflow); end
      req1_valid = 1; req1_last = 0; req1_data = rnd_data();
      step(); step();
      #1;
      nvec++; if ({data_out_valid, id_out_valid} !== 2'b10) begin
         nfail++; $display("FAIL corner_xfer got dv=%b idv=%b expected 1/0", data_out_valid, id_out_valid); end
      step();
      sync_rst = 1; done_valid = 1;
      step();
      sync_rst = 0; done_valid = 0; req1_valid = 0;
      #1;
      nvec++; if ({data_out_valid, req1_ready, id_out_valid} !== 3'b000) begin
         nfail++; $display("FAIL corner_srst_out got dv=%b r1=%b idv=%b expected 000", data_out_valid, req1_ready, id_out_valid); end
      nvec++; if ({status_inflight, status_id, err_underflow} !== 13'd0) begin
         nfail++; $display("FAIL corner_srst_state got inflight=%0d id=%0d err=%b expected 0/0/0", status_inflight, status_id, err_underflow); end
      req0_valid = 1; req0_last = 1; req0_data = rnd_data();
      step();
      #1;
      nvec++; if ({id_out_valid, id_out} !== {1'b1, 6'd0}) begin
         nfail++; $display("FAIL corner_srst_id got idv=%b id=%0d expected 1/0", id_out_valid, id_out); end
      step(); step();
      req0_valid = 0;
   endtask

   task automatic test_random();
      int n;
      do_reset();
      load(0, 6, 4); load(1, 6, 4);
      build_model();
      auto_on = 1; p_idr = 70; p_dr = 60; p_en = 80; p_done = 30;
      for (n = 0; n < 4000 && obs_q.size() < exp_q.size(); n++) begin
         step();
         nvec++; if (status_inflight !== 6'(mi)) begin
            nfail++; $display("FAIL rand_inflight cycle %0d got %0d expected %0d", n, status_inflight, mi); end
      end
      nvec++; if (obs_q.size() != exp_q.size()) begin
         nfail++; $display("FAIL rand_count got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         nvec++; if (obs_q[k] !== exp_q[k]) begin
            nfail++; $display("FAIL rand_beat%0d got src=%b ssrc=%b l=%b d=%h expected src=%b l=%b d=%h",
                              k, obs_q[k].src, obs_q[k].ssrc, obs_q[k].last, obs_q[k].data[31:0],
                              exp_q[k].src, exp_q[k].last, exp_q[k].data[31:0]); end
      end
      for (int k = 0; k < oid_q.size(); k++) begin
         nvec++; if (oid_q[k] !== 6'(k)) begin
            nfail++; $display("FAIL rand_id%0d got %0d expected %0d", k, oid_q[k], k); end
      end
      nvec++; if (err_underflow !== 1'b0) begin
         nfail++; $display("FAIL rand_err got %b expected 0", err_underflow); end
      auto_on = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_credit();
      test_wrap();
      test_backpressure();
      test_enable();
      test_corner();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/sha256_id_issue.md
SHA256_ID_ISSUE -- requirements
Module: sha256_id_issue

Interface
REQ-001 Parameter DATA_W, default 512: message block data width per requester and output.
REQ-002 Parameter MAX_INFLIGHT, default 8, range 1..63: maximum IDs issued but not yet retired.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 nrst  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  grant enable; low blocks new grants, does not abort an active packet.
REQ-006 sync_rst  in  1  synchronous reset, same effect as nrst on the next edge.
REQ-007 req0_data/req0_last/req0_valid in, req0_ready out  DATA_W/1/1/1  requester 0 message stream.
REQ-008 req1_data/req1_last/req1_valid in, req1_ready out  DATA_W/1/1/1  requester 1 message stream.
REQ-009 data_out/data_out_last/data_out_valid out, data_out_ready in  DATA_W/1/1/1  stream to message builder.
REQ-010 id_out/id_out_last/id_out_valid out, id_out_ready in  6/1/1/1  ID stream to ID buffer.
REQ-011 done_valid  in  1  one-cycle pulse, one hash retired downstream.
REQ-012 status_id  out  6  last ID handshaken on id_out.
REQ-013 status_inflight  out  6  current outstanding-ID count.
REQ-014 status_src  out  1  requester owning the last issued ID.
REQ-015 err_underflow  out  1  sticky: done_valid received with zero inflight.

Function
REQ-016 FSM states IDLE, ISSUE, XFER.
REQ-017 IDLE: if en=1, inflight<MAX_INFLIGHT and any reqN_valid=1, register grant and go to ISSUE next edge; else stay.
REQ-018 Arbitration round-robin: rr_ptr names preferred requester; preferred wins if valid, else the other.
REQ-019 Grant latency: first reqN_valid to id_out_valid = 1 cycle.
REQ-020 ISSUE: id_out_valid=1, id_out=next_id, id_out_last=1 (one ID per packet); id_out held stable until id_out_ready.
REQ-021 ISSUE handshake: status_id<=next_id, status_src<=grant, next_id<=next_id+1 modulo 64 (63 wraps to 0), inflight+1, go to XFER.
REQ-022 All reqN_ready and data_out_valid are 0 in IDLE and ISSUE.
REQ-023 XFER: data_out_* combinationally equals granted requester's data/last/valid; granted reqN_ready = data_out_ready; non-granted ready = 0.
REQ-024 XFER handshake with last=1: rr_ptr<=~grant, go to IDLE; earliest next ID one cycle later.
REQ-025 done_valid with inflight>0: inflight-1.
REQ-026 ISSUE handshake and done_valid same cycle: inflight unchanged.
REQ-027 done_valid with inflight=0: inflight stays 0, err_underflow<=1.
REQ-028 inflight=MAX_INFLIGHT: no grant from IDLE until a done_valid lowers it; active packet unaffected.
REQ-029 en falling during ISSUE or XFER: packet completes normally; no further grant while en=0.

Reset
REQ-030 nrst=0 or sync_rst=1: state IDLE, next_id=0, inflight=0, rr_ptr=0, status_id=0, status_src=0, err_underflow=0, all valid/ready outputs 0.
REQ-031 Reset mid-packet abandons it; no ID retracted downstream, no data_out beat emitted after reset.
REQ-032 sync_rst takes priority over every other same-edge event.

Verification
REQ-033 Single packet: req0 sends 3 beats, last on 3rd -> id_out=0 one cycle after valid, then 3 data_out beats, status_id=0, inflight=1.
REQ-034 Contention: both valid continuously, 1-beat packets -> grants alternate 0,1,0,1; IDs 0,1,2,3; status_src follows grant.
REQ-035 Credit limit MAX_INFLIGHT=8, no done_valid -> exactly 8 IDs issued then stall; one done_valid -> 9th ID (8) issued.
REQ-036 Wrap: 65 packets with done_valid each -> IDs 0..63 then 0.
REQ-037 Backpressure: id_out_ready low 5 cycles in ISSUE -> id_out stable, no data beat; data_out_ready toggling -> beats in order, none lost.
REQ-038 Corner: done_valid coincident with issue -> inflight unchanged; done_valid at inflight 0 -> err_underflow=1; sync_rst mid-XFER -> IDLE, next_id=0.
